// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one byte-wide SDRAM controller between two request
// ports. Port 0 is the CPU data side, port 1 the fetch/secondary master.
// Requests are latched into per-port pending registers. One transaction at a
// time is forwarded, and a watchdog aborts transactions the controller never
// completes.
// Optional feature: define SDRAM_ARB_RR_EN for round-robin tie breaking
// (default build uses strict port 0 priority).
module sdram_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_p0_request,
    input  logic              i_p0_wren,
    input  logic [ADDR_W-1:0] i_p0_address,
    input  logic [DATA_W-1:0] i_p0_data,
    output logic [DATA_W-1:0] o_p0_data,
    output logic              o_p0_done,
    output logic              o_p0_err,
    output logic              o_p0_busy,
    input  logic              i_p1_request,
    input  logic              i_p1_wren,
    input  logic [ADDR_W-1:0] i_p1_address,
    input  logic [DATA_W-1:0] i_p1_data,
    output logic [DATA_W-1:0] o_p1_data,
    output logic              o_p1_done,
    output logic              o_p1_err,
    output logic              o_p1_busy,
    output logic              o_mem_request,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_grant;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_pend0;
    logic               r_p0_wren;
    logic [ADDR_W-1:0]  r_p0_address;
    logic [DATA_W-1:0]  r_p0_data;
    logic               r_pend1;
    logic               r_p1_wren;
    logic [ADDR_W-1:0]  r_p1_address;
    logic [DATA_W-1:0]  r_p1_data;

`ifdef SDRAM_ARB_RR_EN
    logic               r_ptr;
`endif

    logic               w_fin;
    logic               w_clr0;
    logic               w_clr1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_win;

    assign o_p0_busy = r_pend0;
    assign o_p1_busy = r_pend1;

    // Completion this edge (done or watchdog) and per-port accept decisions.
    always_comb begin
        w_fin  = 1'b0;
        if (r_state == ST_WAIT) begin
            w_fin = i_mem_done | (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin
            w_fin = 1'b0;
        end
        w_clr0 = w_fin & (r_grant == 1'b0);
        w_clr1 = w_fin & (r_grant == 1'b1);
        // A request landing on its own port's completion edge is accepted.
        w_acc0 = i_p0_request & (~r_pend0 | w_clr0);
        w_acc1 = i_p1_request & (~r_pend1 | w_clr1);
    end

    // Winner selection among pending ports.
    always_comb begin
        w_win = 1'b0;
`ifdef SDRAM_ARB_RR_EN
        if (r_pend0 && r_pend1) begin
            w_win = ~r_ptr;
        end else if (r_pend0) begin
            w_win = 1'b0;
        end else begin
            w_win = 1'b1;
        end
`else
        if (r_pend0) begin
            w_win = 1'b0;
        end else begin
            w_win = 1'b1;
        end
`endif
    end

    // Port 0 pending register and latched request fields.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend0      <= 1'b0;
            r_p0_wren    <= 1'b0;
            r_p0_address <= {ADDR_W{1'b0}};
            r_p0_data    <= {DATA_W{1'b0}};
        end else if (w_acc0) begin
            r_pend0      <= 1'b1;
            r_p0_wren    <= i_p0_wren;
            r_p0_address <= i_p0_address;
            r_p0_data    <= i_p0_data;
        end else if (w_clr0) begin
            r_pend0      <= 1'b0;
        end
    end

    // Port 1 pending register and latched request fields.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend1      <= 1'b0;
            r_p1_wren    <= 1'b0;
            r_p1_address <= {ADDR_W{1'b0}};
            r_p1_data    <= {DATA_W{1'b0}};
        end else if (w_acc1) begin
            r_pend1      <= 1'b1;
            r_p1_wren    <= i_p1_wren;
            r_p1_address <= i_p1_address;
            r_p1_data    <= i_p1_data;
        end else if (w_clr1) begin
            r_pend1      <= 1'b0;
        end
    end

    // Issue/wait FSM with registered controller and completion outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_cnt         <= {CNT_W{1'b0}};
`ifdef SDRAM_ARB_RR_EN
            r_ptr         <= 1'b1;
`endif
            o_mem_request <= 1'b0;
            o_mem_wren    <= 1'b0;
            o_mem_address <= {ADDR_W{1'b0}};
            o_mem_data    <= {DATA_W{1'b0}};
            o_p0_data     <= {DATA_W{1'b0}};
            o_p0_done     <= 1'b0;
            o_p0_err      <= 1'b0;
            o_p1_data     <= {DATA_W{1'b0}};
            o_p1_done     <= 1'b0;
            o_p1_err      <= 1'b0;
        end else begin
            o_mem_request <= 1'b0;
            o_p0_done     <= 1'b0;
            o_p1_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_pend0 || r_pend1) begin
                        r_grant       <= w_win;
`ifdef SDRAM_ARB_RR_EN
                        r_ptr         <= w_win;
`endif
                        o_mem_wren    <= w_win ? r_p1_wren    : r_p0_wren;
                        o_mem_address <= w_win ? r_p1_address : r_p0_address;
                        o_mem_data    <= w_win ? r_p1_data    : r_p0_data;
                        o_mem_request <= 1'b1;
                        r_cnt         <= {CNT_W{1'b0}};
                        r_state       <= ST_WAIT;
                    end else begin
                        r_state       <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_done) begin
                        // Done wins over a coinciding watchdog expiry.
                        if (r_grant == 1'b0) begin
                            o_p0_data <= i_mem_data;
                            o_p0_done <= 1'b1;
                            o_p0_err  <= 1'b0;
                        end else begin
                            o_p1_data <= i_mem_data;
                            o_p1_done <= 1'b1;
                            o_p1_err  <= 1'b0;
                        end
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (r_grant == 1'b0) begin
                            o_p0_data <= {DATA_W{1'b0}};
                            o_p0_done <= 1'b1;
                            o_p0_err  <= 1'b1;
                        end else begin
                            o_p1_data <= {DATA_W{1'b0}};
                            o_p1_done <= 1'b1;
                            o_p1_err  <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (TIMEOUT=16).
// The bench acts as the SDRAM controller, driving i_mem_done/i_mem_data by hand.
module tb_sdram_arbiter;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_p0_request = 1'b0, i_p0_wren = 1'b0;
    logic [ADDR_W-1:0] i_p0_address = '0;
    logic [DATA_W-1:0] i_p0_data = '0;
    logic [DATA_W-1:0] o_p0_data;
    logic              o_p0_done, o_p0_err, o_p0_busy;
    logic              i_p1_request = 1'b0, i_p1_wren = 1'b0;
    logic [ADDR_W-1:0] i_p1_address = '0;
    logic [DATA_W-1:0] i_p1_data = '0;
    logic [DATA_W-1:0] o_p1_data;
    logic              o_p1_done, o_p1_err, o_p1_busy;
    logic              o_mem_request, o_mem_wren;
    logic [ADDR_W-1:0] o_mem_address;
    logic [DATA_W-1:0] o_mem_data;
    logic [DATA_W-1:0] i_mem_data = '0;
    logic              i_mem_done = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_p0_request(i_p0_request), .i_p0_wren(i_p0_wren),
        .i_p0_address(i_p0_address), .i_p0_data(i_p0_data),
        .o_p0_data(o_p0_data), .o_p0_done(o_p0_done),
        .o_p0_err(o_p0_err), .o_p0_busy(o_p0_busy),
        .i_p1_request(i_p1_request), .i_p1_wren(i_p1_wren),
        .i_p1_address(i_p1_address), .i_p1_data(i_p1_data),
        .o_p1_data(o_p1_data), .o_p1_done(o_p1_done),
        .o_p1_err(o_p1_err), .o_p1_busy(o_p1_busy),
        .o_mem_request(o_mem_request), .o_mem_wren(o_mem_wren),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
        .i_mem_data(i_mem_data), .i_mem_done(i_mem_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Controller model: wait n cycles then pulse done with data.
    task automatic mem_respond(input int n, input logic [7:0] d);
        repeat (n) step();
        i_mem_done = 1'b1;
        i_mem_data = d;
        step();
        i_mem_done = 1'b0;
    endtask

    logic [54:0] all_outs;
    assign all_outs = {o_p0_data, o_p0_done, o_p0_err, o_p0_busy,
                       o_p1_data, o_p1_done, o_p1_err, o_p1_busy,
                       o_mem_request, o_mem_wren, o_mem_address, o_mem_data};

    logic [22:0] exp_tie [4];

    initial begin
`ifdef SDRAM_ARB_RR_EN
        exp_tie[0] = 23'h100; exp_tie[1] = 23'h200; exp_tie[2] = 23'h100; exp_tie[3] = 23'h200;
`else
        exp_tie[0] = 23'h100; exp_tie[1] = 23'h100; exp_tie[2] = 23'h100; exp_tie[3] = 23'h100;
`endif
        // Reset state
        step(); step();
        chk("reset_outs", {9'd0, all_outs}, 64'd0);
        i_rst = 1'b0;
        step();

        // Single p0 read
        i_p0_request = 1'b1; i_p0_wren = 1'b0; i_p0_address = 23'h000123;
        step();
        i_p0_request = 1'b0;
        chk("rd_busy", {63'd0, o_p0_busy}, 64'd1);
        chk("rd_noreq_yet", {63'd0, o_mem_request}, 64'd0);
        step();
        chk("rd_issue", {40'd0, o_mem_request, o_mem_wren, o_mem_address}, {40'd0, 1'b1, 1'b0, 23'h000123});
        step();
        chk("rd_req_pulse", {63'd0, o_mem_request}, 64'd0);
        mem_respond(7, 8'h5A);
        chk("rd_done", {52'd0, o_p0_done, o_p0_err, o_p0_busy, o_p1_done, o_p0_data}, {52'd0, 4'b1000, 8'h5A});
        step();
        chk("rd_done_pulse", {63'd0, o_p0_done}, 64'd0);

        // Simultaneous p0 write / p1 read
        i_p0_request = 1'b1; i_p0_wren = 1'b1; i_p0_address = 23'h10; i_p0_data = 8'h3C;
        i_p1_request = 1'b1; i_p1_wren = 1'b0; i_p1_address = 23'h20;
        step();
        i_p0_request = 1'b0; i_p1_request = 1'b0;
        step();
        chk("tie_p0_first", {31'd0, o_mem_request, o_mem_wren, o_mem_address, o_mem_data},
            {31'd0, 1'b1, 1'b1, 23'h10, 8'h3C});
        mem_respond(3, 8'hEE);
        chk("tie_p0_done", {61'd0, o_p0_done, o_p1_done, o_p1_busy}, {61'd0, 3'b101});
        step();
        chk("tie_p1_next", {40'd0, o_mem_request, o_mem_wren, o_mem_address}, {40'd0, 1'b1, 1'b0, 23'h20});
        mem_respond(2, 8'hA7);
        chk("tie_p1_data", {54'd0, o_p1_done, o_p0_done, o_p1_data}, {54'd0, 2'b10, 8'hA7});

        // Back-to-back ties with continuously held requests
        i_p0_request = 1'b1; i_p0_wren = 1'b0; i_p0_address = 23'h100;
        i_p1_request = 1'b1; i_p1_wren = 1'b0; i_p1_address = 23'h200;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("b2b_grant%0d", i), {40'd0, o_mem_request, o_mem_address}, {40'd0, 1'b1, exp_tie[i]});
            mem_respond(1, 8'h11);
        end
        i_p0_request = 1'b0; i_p1_request = 1'b0;
        repeat (8) begin
            step();
            if (o_mem_request) mem_respond(1, 8'h00);
        end
        chk("b2b_drained", {62'd0, o_p0_busy, o_p1_busy}, 64'd0);

        // Drop rule and accept-at-done-edge
        i_p0_request = 1'b1; i_p0_address = 23'h5;
        step();
        i_p0_request = 1'b0;
        step();
        chk("drop_issue5", {40'd0, o_mem_request, o_mem_address}, {40'd0, 1'b1, 23'h5});
        step();
        i_p0_request = 1'b1; i_p0_address = 23'h7;
        step();
        i_p0_request = 1'b0;
        chk("drop_busy_addr", {40'd0, o_p0_busy, o_mem_address}, {40'd0, 1'b1, 23'h5});
        step();
        i_mem_done = 1'b1; i_mem_data = 8'h21;
        i_p0_request = 1'b1; i_p0_address = 23'h9;
        step();
        i_mem_done = 1'b0; i_p0_request = 1'b0;
        chk("drop_done_busy", {54'd0, o_p0_done, o_p0_busy, o_p0_data}, {54'd0, 2'b11, 8'h21});
        step();
        chk("drop_issue9", {40'd0, o_mem_request, o_mem_address}, {40'd0, 1'b1, 23'h9});
        mem_respond(1, 8'h33);
        chk("drop_done9", {54'd0, o_p0_done, o_p0_busy, o_p0_data}, {54'd0, 2'b10, 8'h33});
        repeat (3) step();
        chk("drop_no_stray", {62'd0, o_mem_request, o_p0_busy}, 64'd0);

        // Watchdog on port 1
        i_p1_request = 1'b1; i_p1_address = 23'h40;
        step();
        i_p1_request = 1'b0;
        step();
        chk("tmo_issue", {40'd0, o_mem_request, o_mem_address}, {40'd0, 1'b1, 23'h40});
        repeat (15) step();
        chk("tmo_not_early", {63'd0, o_p1_done}, 64'd0);
        step();
        chk("tmo_abort", {52'd0, o_p1_done, o_p1_err, o_p1_busy, o_p0_done, o_p1_data}, {52'd0, 4'b1100, 8'h00});
        i_mem_done = 1'b1; i_mem_data = 8'h77;
        step();
        i_mem_done = 1'b0;
        step();
        chk("tmo_late_done", {61'd0, o_p0_done, o_p1_done, o_mem_request}, 64'd0);

        // Reset during WAIT
        i_p0_request = 1'b1; i_p0_address = 23'h50;
        step();
        i_p0_request = 1'b0;
        step();
        chk("rstw_issue", {63'd0, o_mem_request}, 64'd1);
        repeat (2) step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rstw_outs", {9'd0, all_outs}, 64'd0);
        i_mem_done = 1'b1; i_mem_data = 8'h99;
        step();
        i_mem_done = 1'b0;
        step();
        chk("rstw_stale_done", {9'd0, all_outs}, 64'd0);
        i_p0_request = 1'b1; i_p0_address = 23'h60;
        step();
        i_p0_request = 1'b0;
        step();
        chk("rstw_new_issue", {40'd0, o_mem_request, o_mem_address}, {40'd0, 1'b1, 23'h60});
        mem_respond(2, 8'hC3);
        chk("rstw_new_done", {53'd0, o_p0_done, o_p0_err, o_p0_busy, o_p0_data}, {53'd0, 3'b100, 8'hC3});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
